// File: rtl/altivec_drv_pkg.sv
// Shared types for the AltiVec issue driver: FSM states, the queued command
// record and default timing constants.
package altivec_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    typedef struct packed {
        logic [7:0]   ins;
        logic [1:0]   nops;
        logic         rc;
        logic [127:0] vra;
        logic [127:0] vrb;
        logic [127:0] vrc;
    } cmd_t;

    localparam int BUSY_WAIT_DEF = 2;
    localparam int TIMEOUT_DEF   = 1024;

endpackage

// File: rtl/altivec_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate count.
module altivec_cmd_fifo
    import altivec_drv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/altivec_issue_driver.sv
// Initiator for the AltiVec DUT port set: pops queued commands, drives
// operands and a go strobe, follows dut_busy and returns one result per command.
module altivec_issue_driver
    import altivec_drv_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int BUSY_WAIT = BUSY_WAIT_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [7:0]   cmd_ins,
    input  logic [1:0]   cmd_nops,
    input  logic         cmd_rc,
    input  logic [127:0] cmd_vra,
    input  logic [127:0] cmd_vrb,
    input  logic [127:0] cmd_vrc,
    output logic [127:0] vra,
    output logic [127:0] vrb,
    output logic [127:0] vrc,
    output logic [7:0]   ins,
    output logic         rc,
    output logic         go1,
    output logic         go2,
    output logic         go3,
    input  logic         dut_busy,
    input  logic [127:0] vrt,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_vrt,
    output logic [7:0]   res_ins,
    output logic         res_err,
    output logic         err_timeout,
    output logic [15:0]  issue_cnt
);

    localparam int CW = $clog2(TIMEOUT > BUSY_WAIT ? TIMEOUT : BUSY_WAIT);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    cmd_t          cmd_in;
    cmd_t          head;
    cmd_t          op;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic          cap_err;
    logic          cnt_clr;
    logic          cnt_inc;

    assign cmd_in    = '{ins: cmd_ins, nops: cmd_nops, rc: cmd_rc,
                         vra: cmd_vra, vrb: cmd_vrb, vrc: cmd_vrc};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;

    altivec_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            issue_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CW'(1);
            if (state == ISSUE)
                issue_cnt <= issue_cnt + 16'd1;
            if (cap_err)
                err_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        cap_err   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        go1       = 1'b0;
        go2       = 1'b0;
        go3       = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !dut_busy) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // An operand count of 0 is issued as a single-operand op.
                go1       = (op.nops <= 2'd1);
                go2       = (op.nops == 2'd2);
                go3       = (op.nops == 2'd3);
                cnt_clr   = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (dut_busy) begin
                    cnt_clr   = 1'b1;
                    state_nxt = WAIT_DONE;
                end else if (cnt == CW'(BUSY_WAIT - 1)) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!dut_busy) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    capture   = 1'b1;
                    cap_err   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands stay on the DUT port from pop until the next pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op      <= '0;
            res_vrt <= '0;
            res_ins <= '0;
            res_err <= 1'b0;
        end else begin
            if (pop)
                op <= head;
            if (capture) begin
                res_vrt <= vrt;
                res_ins <= op.ins;
                res_err <= cap_err;
            end
        end
    end

    assign vra = op.vra;
    assign vrb = op.vrb;
    assign vrc = op.vrc;
    assign ins = op.ins;
    assign rc  = op.rc;

endmodule
